// File: rtl/ebi_ccdl_regs.sv
`default_nettype none
// ============================================================================
// Module   : ebi_ccdl_regs
// Brief    : EBI slave front-end for the CCDL block. It synchronises the EBI
//            strobes, holds the control registers and stages TX words.
// Revision : 1.0 - initial release
// ============================================================================
module ebi_ccdl_regs #(
    parameter logic [23:0] C_TX_ADDR      = 24'h0001E0,
    parameter logic [23:0] C_CTRL_BASE    = 24'h001100,
    parameter logic [23:0] C_RD_ADDR      = 24'h001110,
    parameter logic [23:0] C_RD_ADDR_self = 24'h001112,
    parameter logic [23:0] C_STAT_ADDR    = 24'h001114,
    parameter int          C_CLR_CYCLES   = 4
) (
    input  logic        I_sys_clk,
    input  logic        I_rst,
    input  logic        I_EBI_CS_n,
    input  logic        I_EBI_WE_n,
    input  logic        I_EBI_OE_n,
    input  logic [23:0] I_EBI_Addr,
    input  logic [15:0] I_EBI_Data_in,
    output logic [15:0] O_EBI_Data_out,
    output logic        O_EBI_Data_oe,
    output logic [15:0] O_CCDL_TX_data,
    output logic        O_CCDL_TX_wr,
    input  logic        I_txfifo_full,
    output logic [15:0] O_CCDL_TX_RAM_clear,
    output logic [15:0] O_CCDL_RX_RAM1_clear,
    output logic [15:0] O_CCDL_RX_RAM3_clear_self,
    output logic [15:0] O_CCDL_encode_en,
    output logic [15:0] O_CCDL_decode_en,
    output logic [15:0] O_CCDL_self_test_en,
    input  logic [15:0] I_CCDL_RX_DATA,
    input  logic [15:0] I_CCDL_RX_DATA_self,
    input  logic [15:0] I_CCDL_RAM_status,
    input  logic [15:0] I_CCDL_config_status,
    output logic        O_stage_overflow
);

    localparam int             CW       = $clog2(C_CLR_CYCLES + 1);
    localparam logic [CW-1:0]  CLR_LOAD = CW'(C_CLR_CYCLES);
    localparam logic [CW-1:0]  CLR_LAST = CW'(1);

    // bit0 = stage 1, bit1 = stage 2, bit2 = edge-detect stage
    logic [2:0]  r_cs_sync, r_we_sync, r_oe_sync;
    logic [23:0] r_addr_s1, r_addr_s2, r_addr_s3;
    logic [15:0] r_data_s1, r_data_s2, r_data_s3;
    logic [1:0]  r_flush;
    logic        r_armed;

    logic [15:0]   r_clr     [3];
    logic [CW-1:0] r_clr_cnt [3];
    logic [15:0]   r_en      [3];

    logic [15:0] r_q [4];
    logic [1:0]  r_wp, r_rp;
    logic [2:0]  r_cnt;
    logic [15:0] r_tx_data;
    logic        r_tx_wr;
    logic        r_ovf;
    logic [15:0] r_rd_data;

    logic        w_wr_commit, w_rd_commit;
    logic        w_in_ctrl;
    logic [23:0] w_ctrl_diff;
    logic [2:0]  w_ctrl_off;
    logic [6:0]  w_ctrl_wr;
    logic        w_push, w_q_full, w_push_ok, w_pop;
    logic [15:0] w_rd_mux;

    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            r_cs_sync <= 3'b111;
            r_we_sync <= 3'b111;
            r_oe_sync <= 3'b111;
            r_addr_s1 <= '0;
            r_addr_s2 <= '0;
            r_addr_s3 <= '0;
            r_data_s1 <= '0;
            r_data_s2 <= '0;
            r_data_s3 <= '0;
        end else begin
            r_cs_sync <= {r_cs_sync[1:0], I_EBI_CS_n};
            r_we_sync <= {r_we_sync[1:0], I_EBI_WE_n};
            r_oe_sync <= {r_oe_sync[1:0], I_EBI_OE_n};
            r_addr_s1 <= I_EBI_Addr;
            r_addr_s2 <= r_addr_s1;
            r_addr_s3 <= r_addr_s2;
            r_data_s1 <= I_EBI_Data_in;
            r_data_s2 <= r_data_s1;
            r_data_s3 <= r_data_s2;
        end
    end

    // Stage 2 holds its reset value for two cycles, so only arm once it
    // carries a real pin sample showing CS_n high.
    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            r_flush <= 2'd0;
            r_armed <= 1'b0;
        end else begin
            if (r_flush != 2'd2)
                r_flush <= r_flush + 2'd1;
            if (r_flush == 2'd2 && r_cs_sync[1])
                r_armed <= 1'b1;
        end
    end

    assign w_wr_commit = r_armed & ~r_cs_sync[2] & r_we_sync[1] & ~r_we_sync[2];
    assign w_rd_commit = r_armed & ~r_cs_sync[2] & ~r_oe_sync[1] & r_oe_sync[2];
    assign w_in_ctrl   = (r_addr_s3 >= C_CTRL_BASE) && (r_addr_s3 <= C_CTRL_BASE + 24'd6);
    assign w_ctrl_diff = r_addr_s3 - C_CTRL_BASE;
    assign w_ctrl_off  = w_ctrl_diff[2:0];

    always_comb begin
        w_ctrl_wr = '0;
        for (int i = 0; i < 7; i++)
            w_ctrl_wr[i] = w_wr_commit & w_in_ctrl & (w_ctrl_off == 3'(i));
    end

    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            for (int i = 0; i < 3; i++) begin
                r_clr[i]     <= '0;
                r_clr_cnt[i] <= '0;
                r_en[i]      <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_ctrl_wr[i]) begin
                    r_clr[i]     <= r_data_s3;
                    r_clr_cnt[i] <= CLR_LOAD;
                end else if (r_clr_cnt[i] != '0) begin
                    r_clr_cnt[i] <= r_clr_cnt[i] - CLR_LAST;
                    if (r_clr_cnt[i] == CLR_LAST)
                        r_clr[i] <= '0;
                end
                if (w_ctrl_wr[i+3])
                    r_en[i] <= r_data_s3;
            end
        end
    end

    assign w_push    = w_wr_commit & (r_addr_s3 == C_TX_ADDR);
    assign w_q_full  = (r_cnt == 3'd4);
    assign w_push_ok = w_push & ~w_q_full;
    // Skipping the cycle after a write covers the one-cycle lag of full.
    assign w_pop     = (r_cnt != 3'd0) & ~I_txfifo_full & ~r_tx_wr;

    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            for (int i = 0; i < 4; i++)
                r_q[i] <= '0;
            r_wp      <= 2'd0;
            r_rp      <= 2'd0;
            r_cnt     <= 3'd0;
            r_tx_data <= '0;
            r_tx_wr   <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_tx_wr <= w_pop;
            if (w_push_ok) begin
                r_q[r_wp] <= r_data_s3;
                r_wp      <= r_wp + 2'd1;
            end
            if (w_pop) begin
                r_tx_data <= r_q[r_rp];
                r_rp      <= r_rp + 2'd1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_cnt <= r_cnt + 3'd1;
                2'b01:   r_cnt <= r_cnt - 3'd1;
                default: r_cnt <= r_cnt;
            endcase
            if (w_push && w_q_full)
                r_ovf <= 1'b1;
            else if (w_ctrl_wr[6])
                r_ovf <= 1'b0;
        end
    end

    always_comb begin
        w_rd_mux = '0;
        if (r_addr_s3 == C_RD_ADDR)
            w_rd_mux = I_CCDL_RX_DATA;
        else if (r_addr_s3 == C_RD_ADDR_self)
            w_rd_mux = I_CCDL_RX_DATA_self;
        else if (r_addr_s3 == C_STAT_ADDR)
            w_rd_mux = I_CCDL_RAM_status;
        else if (r_addr_s3 == C_STAT_ADDR + 24'd1)
            w_rd_mux = I_CCDL_config_status;
        else if (w_in_ctrl) begin
            case (w_ctrl_off)
                3'd0:    w_rd_mux = r_clr[0];
                3'd1:    w_rd_mux = r_clr[1];
                3'd2:    w_rd_mux = r_clr[2];
                3'd3:    w_rd_mux = r_en[0];
                3'd4:    w_rd_mux = r_en[1];
                3'd5:    w_rd_mux = r_en[2];
                default: w_rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge I_sys_clk) begin
        if (I_rst)
            r_rd_data <= '0;
        else if (w_rd_commit)
            r_rd_data <= w_rd_mux;
    end

    assign O_EBI_Data_out            = r_rd_data;
    assign O_EBI_Data_oe             = ~r_cs_sync[1] & ~r_oe_sync[1];
    assign O_CCDL_TX_data            = r_tx_data;
    assign O_CCDL_TX_wr              = r_tx_wr;
    assign O_CCDL_TX_RAM_clear       = r_clr[0];
    assign O_CCDL_RX_RAM1_clear      = r_clr[1];
    assign O_CCDL_RX_RAM3_clear_self = r_clr[2];
    assign O_CCDL_encode_en          = r_en[0];
    assign O_CCDL_decode_en          = r_en[1];
    assign O_CCDL_self_test_en       = r_en[2];
    assign O_stage_overflow          = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_ebi_ccdl_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_ebi_ccdl_regs
// Brief    : Directed self-checking bench for ebi_ccdl_regs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ebi_ccdl_regs;

    localparam logic [23:0] TX   = 24'h0001E0;
    localparam logic [23:0] BASE = 24'h001100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs_n = 1'b1, we_n = 1'b1, oe_n = 1'b1;
    logic [23:0] addr = '0;
    logic [15:0] din = '0;
    logic        full = 1'b0;
    logic [15:0] rx = '0, rx_self = '0, ram_st = '0, cfg_st = '0;
    logic [15:0] dout, tx_data, clr_tx, clr_rx1, clr_rx3, enc, dec, stn;
    logic        doe, tx_wr, ovf;

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;
    logic [15:0] mon_d [$];
    int          mon_c [$];

    ebi_ccdl_regs dut (
        .I_sys_clk                 (clk),
        .I_rst                     (rst),
        .I_EBI_CS_n                (cs_n),
        .I_EBI_WE_n                (we_n),
        .I_EBI_OE_n                (oe_n),
        .I_EBI_Addr                (addr),
        .I_EBI_Data_in             (din),
        .O_EBI_Data_out            (dout),
        .O_EBI_Data_oe             (doe),
        .O_CCDL_TX_data            (tx_data),
        .O_CCDL_TX_wr              (tx_wr),
        .I_txfifo_full             (full),
        .O_CCDL_TX_RAM_clear       (clr_tx),
        .O_CCDL_RX_RAM1_clear      (clr_rx1),
        .O_CCDL_RX_RAM3_clear_self (clr_rx3),
        .O_CCDL_encode_en          (enc),
        .O_CCDL_decode_en          (dec),
        .O_CCDL_self_test_en       (stn),
        .I_CCDL_RX_DATA            (rx),
        .I_CCDL_RX_DATA_self       (rx_self),
        .I_CCDL_RAM_status         (ram_st),
        .I_CCDL_config_status      (cfg_st),
        .O_stage_overflow          (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_wr === 1'b1) begin
            mon_d.push_back(tx_data);
            mon_c.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mon_at(input int i);
        if (i < mon_d.size()) return mon_d[i];
        return 16'hxxxx;
    endfunction

    function automatic int cyc_at(input int i);
        if (i < mon_c.size()) return mon_c[i];
        return -1000;
    endfunction

    task automatic wr_begin(input logic [23:0] a, input logic [15:0] d);
        @(negedge clk);
        addr = a; din = d; cs_n = 1'b0;
        @(negedge clk);
        we_n = 1'b0;
        repeat (2) @(negedge clk);
        we_n = 1'b1;
    endtask

    task automatic wait_commit;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic bus_end;
        @(negedge clk);
        cs_n = 1'b1; oe_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic ebi_write(input logic [23:0] a, input logic [15:0] d);
        wr_begin(a, d);
        wait_commit();
        bus_end();
    endtask

    task automatic ebi_read(input logic [23:0] a, output logic [15:0] d, output logic oe);
        @(negedge clk);
        addr = a; cs_n = 1'b0;
        @(negedge clk);
        oe_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        d  = dout;
        oe = doe;
        bus_end();
    endtask

    initial begin
        logic [15:0] rd;
        logic        rd_oe;
        int          c0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        check("rst_tx_wr", tx_wr, 1'b0);
        check("rst_dout", dout, 16'h0000);
        check("rst_oe", doe, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_clr", {clr_tx, clr_rx1}, 32'h0);
        check("rst_en", {enc, dec}, 32'h0);

        // Control write and readback
        wr_begin(BASE + 24'd3, 16'h0001);
        wait_commit();
        check("enc_commit", enc, 16'h0001);
        bus_end();
        ebi_read(BASE + 24'd3, rd, rd_oe);
        check("enc_readback", rd, 16'h0001);

        // Clear pulse: four cycles high then zero
        wr_begin(BASE, 16'hFFFF);
        wait_commit();
        check("clr_c1", clr_tx, 16'hFFFF);
        for (int k = 2; k <= 4; k++) begin
            @(posedge clk); #1;
            check("clr_hold", clr_tx, 16'hFFFF);
        end
        @(posedge clk); #1;
        check("clr_done", clr_tx, 16'h0000);
        bus_end();

        // TX drain
        mon_d.delete(); mon_c.delete();
        wr_begin(TX, 16'hA5A5);
        wait_commit();
        c0 = cyc;
        bus_end();
        ebi_write(TX, 16'h5A5A);
        repeat (5) @(negedge clk);
        check("tx_count", mon_d.size(), 2);
        check("tx_d0", mon_at(0), 16'hA5A5);
        check("tx_d1", mon_at(1), 16'h5A5A);
        check("tx_lat", cyc_at(0) - c0, 1);
        check("tx_gap", (cyc_at(1) - cyc_at(0)) >= 2, 1);

        // Overflow with full held high, then drain and clear
        @(negedge clk);
        full = 1'b1;
        mon_d.delete(); mon_c.delete();
        ebi_write(TX, 16'h1111);
        ebi_write(TX, 16'h2222);
        ebi_write(TX, 16'h3333);
        ebi_write(TX, 16'h4444);
        check("ovf_at4", ovf, 1'b0);
        ebi_write(TX, 16'h5555);
        check("ovf_at5", ovf, 1'b1);
        check("halt_none", mon_d.size(), 0);
        full = 1'b0;
        repeat (12) @(negedge clk);
        check("drain_count", mon_d.size(), 4);
        check("drain_d0", mon_at(0), 16'h1111);
        check("drain_d1", mon_at(1), 16'h2222);
        check("drain_d2", mon_at(2), 16'h3333);
        check("drain_d3", mon_at(3), 16'h4444);
        for (int i = 0; i < 3; i++)
            check("drain_gap", cyc_at(i+1) - cyc_at(i), 2);
        check("ovf_sticky", ovf, 1'b1);
        ebi_write(BASE + 24'd6, 16'h0000);
        check("ovf_clear", ovf, 1'b0);

        // Read mux
        rx = 16'h1234; rx_self = 16'hBEEF; cfg_st = 16'hC0DE; ram_st = 16'h0F0F;
        ebi_read(24'h001110, rd, rd_oe);
        check("rd_rx", rd, 16'h1234);
        check("rd_oe", rd_oe, 1'b1);
        check("oe_idle", doe, 1'b0);
        check("rd_hold", dout, 16'h1234);
        ebi_read(24'h001112, rd, rd_oe);
        check("rd_self", rd, 16'hBEEF);
        ebi_read(24'h001114, rd, rd_oe);
        check("rd_ram", rd, 16'h0F0F);
        ebi_read(24'h001115, rd, rd_oe);
        check("rd_cfg", rd, 16'hC0DE);
        ebi_read(24'h00FFFF, rd, rd_oe);
        check("rd_unmapped", rd, 16'h0000);

        // Reset during an access in progress
        mon_d.delete(); mon_c.delete();
        @(negedge clk);
        addr = TX; din = 16'hDEAD; cs_n = 1'b0; we_n = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        we_n = 1'b1;
        repeat (8) @(negedge clk);
        check("rstmid_no_tx", mon_d.size(), 0);
        check("rstmid_enc", enc, 16'h0000);
        cs_n = 1'b1;
        repeat (4) @(negedge clk);
        ebi_write(TX, 16'h7777);
        repeat (5) @(negedge clk);
        check("rearm_count", mon_d.size(), 1);
        check("rearm_d0", mon_at(0), 16'h7777);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ebi_ccdl_regs.md
# ebi_ccdl_regs

EBI slave front-end that sits directly upstream of the CCDL block. It synchronises asynchronous EBI strobes into `I_sys_clk` and holds the CCDL control registers. It buffers host TX words in a 4-entry staging queue, which absorbs TX-FIFO backpressure, and it drives the EBI read-data bus from CCDL RX data and status.

## Interface
Parameters:
- `C_TX_ADDR`, 24'h0001E0, write address of TX data word
- `C_CTRL_BASE`, 24'h001100, control registers at offsets +0..+6 (word addresses)
- `C_RD_ADDR`, 24'h001110, read address of RX data
- `C_RD_ADDR_self`, 24'h001112, read address of self-test RX data
- `C_STAT_ADDR`, 24'h001114, read address of RAM status; +1 is config status
- `C_CLR_CYCLES`, 4, number of cycles a written clear register stays asserted

Ports:
- `I_sys_clk`  in  1  system clock; single clock domain
- `I_rst`  in  1  synchronous reset, active-high
- `I_EBI_CS_n`, `I_EBI_WE_n`, `I_EBI_OE_n`  in  1 each  asynchronous EBI strobes
- `I_EBI_Addr`  in  24  EBI address
- `I_EBI_Data_in`  in  16  EBI write data
- `O_EBI_Data_out`  out  16  EBI read data
- `O_EBI_Data_oe`  out  1  read-bus output enable
- `O_CCDL_TX_data`  out  16  word to the CCDL TX FIFO
- `O_CCDL_TX_wr`  out  1  one-cycle TX write strobe
- `I_txfifo_full`  in  1  CCDL TX FIFO full (registered)
- `O_CCDL_TX_RAM_clear`, `O_CCDL_RX_RAM1_clear`, `O_CCDL_RX_RAM3_clear_self`  out  16 each  self-clearing clear registers
- `O_CCDL_encode_en`, `O_CCDL_decode_en`, `O_CCDL_self_test_en`  out  16 each  persistent enable registers
- `I_CCDL_RX_DATA`, `I_CCDL_RX_DATA_self`, `I_CCDL_RAM_status`, `I_CCDL_config_status`  in  16 each  read sources
- `O_stage_overflow`  out  1  sticky flag set when a TX word is dropped

## Operation
- **Input synchronisation:** CS_n, WE_n and OE_n pass through a 2-FF synchroniser, plus a third stage used for edge detection. Reset value of each stage is 1. Addr and Data_in pass through three matching register stages.
- **Write commit:** fires when synced WE_n goes 0→1 (stage 2 = 1, stage 3 = 0) while stage-3 CS_n = 0. Address and data are taken from stage 3.
- **Write decode:**
  - `C_TX_ADDR`: push the word into the staging queue.
  - Queue full (4 entries) at push: the word is dropped and `O_stage_overflow` is set.
  - `C_CTRL_BASE`+0..+2: load the corresponding clear register. It returns to 0 after `C_CLR_CYCLES` cycles. A rewrite during the hold reloads the value and restarts the count.
  - `C_CTRL_BASE`+3..+5: load encode_en, decode_en and self_test_en respectively. These hold until rewritten.
  - `C_CTRL_BASE`+6: any write clears `O_stage_overflow`. If an overflow occurs in the same cycle, the flag stays set.
  - Any other address: ignored.
- **Read:**
  - On the synced OE_n falling edge with CS_n low, `O_EBI_Data_out` registers the source selected by stage-3 Addr. Sources: RX data, self-test RX data, RAM status, config status, or control registers +0..+5.
  - Unmapped addresses read 16'h0000.
  - `O_EBI_Data_out` holds its value until the next read edge.
  - `O_EBI_Data_oe` = (synced CS_n = 0 and synced OE_n = 0).
- **Drain:** when the queue is non-empty, `I_txfifo_full` = 0, and `O_CCDL_TX_wr` was 0 in the previous cycle:
  - pop the head entry;
  - drive `O_CCDL_TX_data` with it;
  - pulse `O_CCDL_TX_wr` for one cycle.
  
  This limits the drain to at most one word per 2 cycles, which tolerates the one-cycle latency of full. A simultaneous push and pop is legal, and the occupancy count is unchanged.
- **Queue structure:** 4-entry circular buffer with 2-bit read/write pointers (wrap 3→0) and a 3-bit count from 0 to 4.
- **Reset re-arm:** after reset, write and read commits are blocked until synced CS_n is seen high. An EBI access already in progress when reset releases is therefore ignored.

## Timing
- All registers reset synchronously under `I_rst`. Reset values:
  - all 16-bit outputs: 0;
  - `O_CCDL_TX_wr`, `O_EBI_Data_oe`, `O_stage_overflow`: 0;
  - queue: empty, pointers 0.
- Pin WE_n rising edge to register or queue update: 3 clock edges.
- Queue push to earliest `O_CCDL_TX_wr`: 1 cycle later.
- Pin OE_n falling edge to `O_EBI_Data_out` valid: 3 edges.
- Clear register: nonzero for exactly `C_CLR_CYCLES` cycles, starting the cycle after commit.
- `I_txfifo_full` high halts the drain from the next eligible cycle. Queue contents are retained.

## Test plan
- **Reset and control readback:** reset, then write 16'h0001 to `C_CTRL_BASE`+3 → `O_CCDL_encode_en` = 16'h0001 three cycles after WE_n rises. Reading +3 returns 16'h0001.
- **Clear pulse:** write 16'hFFFF to +0 → `O_CCDL_TX_RAM_clear` = 16'hFFFF for exactly 4 cycles, then 0.
- **TX back-to-back drain:** write 16'hA5A5 then 16'h5A5A to `C_TX_ADDR` with full = 0 → two `O_CCDL_TX_wr` pulses at least 2 cycles apart, with data in order.
- **Overflow and clear:** hold full = 1 and write 5 TX words → queue holds the first 4 and `O_stage_overflow` = 1. Release full → 4 words drain in order. Write to +6 → flag = 0.
- **Read mux:** set `I_CCDL_RX_DATA` = 16'h1234 and read `C_RD_ADDR` → `O_EBI_Data_out` = 16'h1234 and `O_EBI_Data_oe` = 1 while OE_n is low. Read 24'h00FFFF → 16'h0000.
- **Reset mid-access:** assert `I_rst` while CS_n and WE_n are low, then release and raise WE_n → no commit occurs and the queue stays empty.
